// File: rtl/pr_fetch_sequencer.sv
// pr_fetch_sequencer: credit-limited line fetcher that streams an element array into a line buffer.
// Define PR_FETCH_PERF_EN to add busy/credit-stall/full-stall performance counters.
module pr_fetch_sequencer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int LOG_DEPTH  = 4,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_elem_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_req_valid,
    input  logic                  i_rd_req_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_req_addr,
    input  logic                  i_rd_rsp_valid,
    output logic                  o_rd_rsp_ready,
    input  logic [FULL_WIDTH-1:0] i_rd_rsp_data,
    output logic                  o_buf_wrreq,
    output logic [FULL_WIDTH-1:0] o_buf_wdata,
    output logic                  o_buf_last,
    output logic [7:0]            o_buf_bounds,
    input  logic                  i_buf_full,
    input  logic                  i_line_free
`ifdef PR_FETCH_PERF_EN
    ,
    output logic [31:0]           o_perf_cycles,
    output logic [31:0]           o_perf_credit_stall,
    output logic [31:0]           o_perf_full_stall
`endif
);
    localparam int unsigned MAX_ELEMS = FULL_WIDTH / WIDTH;
    localparam int unsigned LINE_BYTES = FULL_WIDTH / 8;
    localparam logic [LOG_DEPTH:0] DEPTH = {1'b1, {LOG_DEPTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             r_state;
    logic [31:0]        r_total;
    logic [7:0]         r_tail;
    logic [31:0]        r_req_cnt;
    logic [31:0]        r_rsp_cnt;
    logic [LOG_DEPTH:0] r_credits;

    logic               w_req_hs;
    logic               w_free;
    logic [LOG_DEPTH:0] w_credits_nx;
    logic [31:0]        w_req_cnt_nx;
    logic               w_final;
    logic [32:0]        w_sum;
    logic [31:0]        w_total;
    logic [31:0]        w_rem;
    logic [7:0]         w_tail;

    assign w_sum   = {1'b0, i_elem_count} + 33'(MAX_ELEMS - 1);
    assign w_total = 32'(w_sum / 33'(MAX_ELEMS));
    assign w_rem   = i_elem_count % MAX_ELEMS;
    assign w_tail  = (w_rem == 32'd0) ? 8'(MAX_ELEMS) : w_rem[7:0];

    // A line_free alongside a new request cancels out, even at zero credits.
    assign w_req_hs     = o_rd_req_valid & i_rd_req_ready;
    assign w_free       = i_line_free & ((r_credits != '0) | w_req_hs);
    assign w_credits_nx = r_credits + {{LOG_DEPTH{1'b0}}, w_req_hs} - {{LOG_DEPTH{1'b0}}, w_free};
    assign w_req_cnt_nx = r_req_cnt + 32'(w_req_hs);

    assign o_rd_rsp_ready = ~i_buf_full;
    assign o_buf_wrreq    = i_rd_rsp_valid & ~i_buf_full & o_busy;
    assign o_buf_wdata    = i_rd_rsp_data;
    assign w_final        = o_buf_wrreq & (r_rsp_cnt == r_total - 32'd1);
    assign o_buf_last     = w_final;
    assign o_buf_bounds   = w_final ? r_tail : (o_busy ? 8'(MAX_ELEMS) : 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_total        <= '0;
            r_tail         <= '0;
            r_req_cnt      <= '0;
            r_rsp_cnt      <= '0;
            r_credits      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_rd_req_valid <= 1'b0;
            o_rd_req_addr  <= '0;
        end else begin
            o_done    <= 1'b0;
            r_credits <= w_credits_nx;
            if (r_state == IDLE) begin
                if (i_start && i_elem_count == 32'd0) begin
                    o_done <= 1'b1;
                end else if (i_start) begin
                    r_state        <= ISSUE;
                    r_total        <= w_total;
                    r_tail         <= w_tail;
                    r_req_cnt      <= '0;
                    r_rsp_cnt      <= '0;
                    o_busy         <= 1'b1;
                    o_rd_req_addr  <= i_base_addr;
                    o_rd_req_valid <= w_credits_nx < DEPTH;
                end
            end else begin
                if (w_req_hs) begin
                    r_req_cnt     <= w_req_cnt_nx;
                    o_rd_req_addr <= o_rd_req_addr + ADDR_WIDTH'(LINE_BYTES);
                end
                if (o_buf_wrreq)
                    r_rsp_cnt <= r_rsp_cnt + 32'd1;
                if (w_final) begin
                    r_state        <= IDLE;
                    o_busy         <= 1'b0;
                    o_done         <= 1'b1;
                    o_rd_req_valid <= 1'b0;
                end else if (r_state == ISSUE) begin
                    o_rd_req_valid <= (w_req_cnt_nx < r_total) && (w_credits_nx < DEPTH);
                    if (w_req_cnt_nx == r_total)
                        r_state <= DRAIN;
                end
            end
        end
    end

`ifdef PR_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_cycles       <= '0;
            o_perf_credit_stall <= '0;
            o_perf_full_stall   <= '0;
        end else if (r_state == IDLE && i_start) begin
            o_perf_cycles       <= '0;
            o_perf_credit_stall <= '0;
            o_perf_full_stall   <= '0;
        end else if (o_busy) begin
            o_perf_cycles <= o_perf_cycles + 32'd1;
            if (r_state == ISSUE && r_req_cnt < r_total && r_credits == DEPTH)
                o_perf_credit_stall <= o_perf_credit_stall + 32'd1;
            if (i_rd_rsp_valid && i_buf_full)
                o_perf_full_stall <= o_perf_full_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pr_fetch_sequencer.sv
// tb_pr_fetch_sequencer: directed checks of request issue, credits, response tagging and reset.
module tb_pr_fetch_sequencer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [63:0]  i_base_addr;
    logic [31:0]  i_elem_count;
    logic         o_busy;
    logic         o_done;
    logic         o_rd_req_valid;
    logic         i_rd_req_ready;
    logic [63:0]  o_rd_req_addr;
    logic         i_rd_rsp_valid;
    logic         o_rd_rsp_ready;
    logic [511:0] i_rd_rsp_data;
    logic         o_buf_wrreq;
    logic [511:0] o_buf_wdata;
    logic         o_buf_last;
    logic [7:0]   o_buf_bounds;
    logic         i_buf_full;
    logic         i_line_free;

    int n_vec = 0;
    int n_err = 0;
    int n_req;

    always #5 clk = ~clk;

    pr_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_elem_count(i_elem_count), .o_busy(o_busy), .o_done(o_done),
        .o_rd_req_valid(o_rd_req_valid), .i_rd_req_ready(i_rd_req_ready),
        .o_rd_req_addr(o_rd_req_addr), .i_rd_rsp_valid(i_rd_rsp_valid),
        .o_rd_rsp_ready(o_rd_rsp_ready), .i_rd_rsp_data(i_rd_rsp_data),
        .o_buf_wrreq(o_buf_wrreq), .o_buf_wdata(o_buf_wdata), .o_buf_last(o_buf_last),
        .o_buf_bounds(o_buf_bounds), .i_buf_full(i_buf_full), .i_line_free(i_line_free)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [63:0] base, input logic [31:0] cnt);
        i_start = 1'b1;
        i_base_addr = base;
        i_elem_count = cnt;
        tick();
        i_start = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [511:0] d, input logic el, input logic [7:0] eb);
        i_rd_rsp_valid = 1'b1;
        i_rd_rsp_data = d;
        #1;
        chk({tag, "_wrreq"}, 512'(o_buf_wrreq), 512'(1'b1));
        chk({tag, "_wdata"}, o_buf_wdata, d);
        chk({tag, "_last"}, 512'(o_buf_last), 512'(el));
        chk({tag, "_bounds"}, 512'(o_buf_bounds), 512'(eb));
        tick();
        i_rd_rsp_valid = 1'b0;
    endtask

    task automatic count_reqs(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (o_rd_req_valid && i_rd_req_ready) n++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        i_base_addr = '0;
        i_elem_count = '0;
        i_rd_req_ready = 1'b0;
        i_rd_rsp_valid = 1'b0;
        i_rd_rsp_data = '0;
        i_buf_full = 1'b0;
        i_line_free = 1'b0;
        tick();
        chk("rst_busy", 512'(o_busy), 512'(1'b0));
        chk("rst_done", 512'(o_done), 512'(1'b0));
        chk("rst_valid", 512'(o_rd_req_valid), 512'(1'b0));
        chk("rst_addr", 512'(o_rd_req_addr), 512'(64'h0));
        chk("rst_last", 512'(o_buf_last), 512'(1'b0));
        chk("rst_bounds", 512'(o_buf_bounds), 512'(8'd0));
        rst_n = 1'b1;
        tick();

        // 20 elements: three lines, tail of 4
        i_rd_req_ready = 1'b1;
        start_job(64'h1000, 32'd20);
        chk("t1_busy", 512'(o_busy), 512'(1'b1));
        chk("t1_valid0", 512'(o_rd_req_valid), 512'(1'b1));
        chk("t1_addr0", 512'(o_rd_req_addr), 512'(64'h1000));
        tick();
        chk("t1_addr1", 512'(o_rd_req_addr), 512'(64'h1040));
        tick();
        chk("t1_addr2", 512'(o_rd_req_addr), 512'(64'h1080));
        tick();
        chk("t1_valid_end", 512'(o_rd_req_valid), 512'(1'b0));
        resp("t1_r0", {16{32'hA0A0_0001}}, 1'b0, 8'd8);
        resp("t1_r1", {16{32'hA0A0_0002}}, 1'b0, 8'd8);
        resp("t1_r2", {16{32'hA0A0_0003}}, 1'b1, 8'd4);
        chk("t1_done", 512'(o_done), 512'(1'b1));
        chk("t1_busy_end", 512'(o_busy), 512'(1'b0));
        tick();
        chk("t1_done_pulse", 512'(o_done), 512'(1'b0));

        // 16 elements: two full lines; then an empty job
        start_job(64'h8000, 32'd16);
        chk("t2_addr0", 512'(o_rd_req_addr), 512'(64'h8000));
        tick();
        tick();
        chk("t2_valid_end", 512'(o_rd_req_valid), 512'(1'b0));
        resp("t2_r0", {16{32'hB0B0_0001}}, 1'b0, 8'd8);
        resp("t2_r1", {16{32'hB0B0_0002}}, 1'b1, 8'd8);
        chk("t2_done", 512'(o_done), 512'(1'b1));
        tick();
        start_job(64'h9000, 32'd0);
        chk("t2z_done", 512'(o_done), 512'(1'b1));
        chk("t2z_busy", 512'(o_busy), 512'(1'b0));
        chk("t2z_valid", 512'(o_rd_req_valid), 512'(1'b0));
        tick();
        chk("t2z_done_pulse", 512'(o_done), 512'(1'b0));

        // 25 lines with no consumer: credit limit of 16
        do_reset();
        start_job(64'h20000, 32'd200);
        count_reqs(30, n_req);
        chk("t3_reqs_limit", 512'(n_req), 512'(16));
        chk("t3_valid_stall", 512'(o_rd_req_valid), 512'(1'b0));
        i_line_free = 1'b1;
        tick();
        i_line_free = 1'b0;
        count_reqs(10, n_req);
        chk("t3_reqs_one_more", 512'(n_req), 512'(1));

        // line_free coinciding with a handshake leaves credits unchanged
        i_rd_req_ready = 1'b0;
        i_line_free = 1'b1;
        tick();
        i_line_free = 1'b0;
        chk("t6_valid_freed", 512'(o_rd_req_valid), 512'(1'b1));
        i_rd_req_ready = 1'b1;
        i_line_free = 1'b1;
        tick();
        i_line_free = 1'b0;
        chk("t6_valid_after_both", 512'(o_rd_req_valid), 512'(1'b1));
        count_reqs(5, n_req);
        chk("t6_reqs_after_both", 512'(n_req), 512'(1));
        chk("t6_addr", 512'(o_rd_req_addr), 512'(64'h204C0));
        start_job(64'h9000, 32'd8);
        chk("t6_busy_ignore", 512'(o_busy), 512'(1'b1));
        chk("t6_addr_ignore", 512'(o_rd_req_addr), 512'(64'h204C0));
        chk("t6_valid_ignore", 512'(o_rd_req_valid), 512'(1'b0));

        // backpressure on requests and buffer, then mid-job reset
        do_reset();
        i_rd_req_ready = 1'b0;
        start_job(64'h3000, 32'd32);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_valid_hold", 512'(o_rd_req_valid), 512'(1'b1));
            chk("t4_addr_hold", 512'(o_rd_req_addr), 512'(64'h3000));
        end
        i_rd_req_ready = 1'b1;
        tick();
        chk("t4_addr1", 512'(o_rd_req_addr), 512'(64'h3040));
        tick();
        chk("t4_addr2", 512'(o_rd_req_addr), 512'(64'h3080));
        i_rd_req_ready = 1'b0;
        i_rd_rsp_valid = 1'b1;
        i_rd_rsp_data = {16{32'hC0C0_0001}};
        i_buf_full = 1'b1;
        #1;
        chk("t4_full_wrreq", 512'(o_buf_wrreq), 512'(1'b0));
        chk("t4_full_ready", 512'(o_rd_rsp_ready), 512'(1'b0));
        tick();
        i_buf_full = 1'b0;
        resp("t4_r0", {16{32'hC0C0_0001}}, 1'b0, 8'd8);
        resp("t5_r1", {16{32'hC0C0_0002}}, 1'b0, 8'd8);
        chk("t5_valid_pre", 512'(o_rd_req_valid), 512'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 512'(o_busy), 512'(1'b0));
        chk("t5_rst_valid", 512'(o_rd_req_valid), 512'(1'b0));
        chk("t5_rst_addr", 512'(o_rd_req_addr), 512'(64'h0));
        tick();
        rst_n = 1'b1;
        i_rd_rsp_valid = 1'b1;
        #1;
        chk("t5_idle_drop", 512'(o_buf_wrreq), 512'(1'b0));
        i_rd_rsp_valid = 1'b0;
        i_rd_req_ready = 1'b1;
        start_job(64'h4000, 32'd8);
        chk("t5_addr", 512'(o_rd_req_addr), 512'(64'h4000));
        count_reqs(4, n_req);
        chk("t5_reqs", 512'(n_req), 512'(1));
        resp("t5_single", {16{32'hD0D0_0001}}, 1'b1, 8'd8);
        chk("t5_done", 512'(o_done), 512'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
